// File: rtl/mem_tx_scheduler.sv
// Shares the serial TX pins between the instruction prefetcher and the data port:
// header, address payload and optional write-data payload, with a read-outstanding limit.
// Optional build macro MEM_TX_ROUND_ROBIN_EN: round-robin tie-break instead of fixed data-port priority.
module mem_tx_scheduler #(
  parameter int IO_BITS         = 2,
  parameter int PAYLOAD_CYCLES  = 8,
  parameter int CMD_BITS        = 4,
  parameter int MAX_OUTSTANDING = 2,
  localparam int CNT_W          = $clog2(PAYLOAD_CYCLES) + 1,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pf_valid,
  input  logic [CMD_BITS-1:0] pf_cmd,
  input  logic [IO_BITS-1:0]  pf_data,
  output logic                pf_started,
  output logic                pf_data_next,
  input  logic                dp_valid,
  input  logic                dp_write,
  input  logic [CMD_BITS-1:0] dp_cmd,
  input  logic [IO_BITS-1:0]  dp_data,
  output logic                dp_started,
  output logic                dp_data_next,
  input  logic                rx_reply_done,
  output logic [IO_BITS-1:0]  tx_pins,
  output logic                tx_active,
  output logic [CNT_W-1:0]    tx_counter,
  output logic                tx_done,
  output logic [OUT_W-1:0]    outstanding
);

  localparam int HDR_CYCLES = CMD_BITS / IO_BITS;
  localparam int HDR_CW     = (HDR_CYCLES > 1) ? $clog2(HDR_CYCLES) : 1;

  localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(PAYLOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(2 * PAYLOAD_CYCLES - 1);
  localparam logic [HDR_CW-1:0] HDR_LOAD  = HDR_CW'(HDR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_ADDR,
    S_DATA
  } state_t;

  state_t              state_q, state_d;
  logic [CMD_BITS-1:0] hdr_q, hdr_d;
  logic [HDR_CW-1:0]   hdr_left_q, hdr_left_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_pf_q, owner_pf_d;
  logic                write_q, write_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;

  logic pf_elig, dp_elig;
  logic grant_pf, grant_dp;
  logic read_grant, reply_dec;

`ifdef MEM_TX_ROUND_ROBIN_EN
  logic last_pf_q;
`endif

  // Grants are suppressed while reset is asserted so no strobe escapes a reset cycle.
  always_comb begin
    pf_elig  = pf_valid && (outstanding_q < OUT_MAX);
    dp_elig  = dp_valid && (dp_write || (outstanding_q < OUT_MAX));
    grant_pf = 1'b0;
    grant_dp = 1'b0;
    if ((state_q == S_IDLE) && !reset) begin
`ifdef MEM_TX_ROUND_ROBIN_EN
      if (pf_elig && dp_elig) begin
        grant_pf = !last_pf_q;
        grant_dp = last_pf_q;
      end else begin
        grant_pf = pf_elig;
        grant_dp = dp_elig;
      end
`else
      grant_dp = dp_elig;
      grant_pf = pf_elig && !dp_elig;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    hdr_left_d   = hdr_left_q;
    cnt_d        = cnt_q;
    owner_pf_d   = owner_pf_q;
    write_d      = write_q;
    pf_started   = 1'b0;
    dp_started   = 1'b0;
    pf_data_next = 1'b0;
    dp_data_next = 1'b0;
    tx_pins      = '0;
    tx_active    = 1'b0;
    tx_counter   = '0;
    tx_done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_dp) begin
          dp_started = 1'b1;
          hdr_d      = dp_cmd;
          owner_pf_d = 1'b0;
          write_d    = dp_write;
          hdr_left_d = HDR_LOAD;
          state_d    = S_HEADER;
        end else if (grant_pf) begin
          pf_started = 1'b1;
          hdr_d      = pf_cmd;
          owner_pf_d = 1'b1;
          write_d    = 1'b0;
          hdr_left_d = HDR_LOAD;
          state_d    = S_HEADER;
        end
      end

      S_HEADER: begin
        tx_active = 1'b1;
        tx_pins   = hdr_q[IO_BITS-1:0];
        hdr_d     = hdr_q >> IO_BITS;
        if (hdr_left_q == '0) begin
          cnt_d   = '0;
          state_d = S_ADDR;
        end else begin
          hdr_left_d = hdr_left_q - 1'b1;
        end
      end

      S_ADDR, S_DATA: begin
        tx_active    = 1'b1;
        tx_counter   = cnt_q;
        tx_pins      = owner_pf_q ? pf_data : dp_data;
        pf_data_next = owner_pf_q;
        dp_data_next = !owner_pf_q;
        cnt_d        = cnt_q + 1'b1;
        if ((state_q == S_ADDR) && (cnt_q == ADDR_LAST)) begin
          if (write_q) begin
            state_d = S_DATA;
          end else begin
            tx_done = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else if ((state_q == S_DATA) && (cnt_q == DATA_LAST)) begin
          tx_done = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A reply arriving with nothing outstanding is spurious and dropped.
  always_comb begin
    read_grant    = grant_pf || (grant_dp && !dp_write);
    reply_dec     = rx_reply_done && (outstanding_q != '0);
    outstanding_d = outstanding_q;
    if (read_grant && !reply_dec && (outstanding_q < OUT_MAX)) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (reply_dec && !read_grant) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  assign outstanding = outstanding_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hdr_q         <= '0;
      hdr_left_q    <= '0;
      cnt_q         <= '0;
      owner_pf_q    <= 1'b0;
      write_q       <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      hdr_left_q    <= hdr_left_d;
      cnt_q         <= cnt_d;
      owner_pf_q    <= owner_pf_d;
      write_q       <= write_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef MEM_TX_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pf_q <= 1'b0;
    end else if (grant_pf || grant_dp) begin
      last_pf_q <= grant_pf;
    end
  end
`endif

endmodule

// File: tb/tb_mem_tx_scheduler.sv
// Directed bench for mem_tx_scheduler: reset, prefetch read, data-port write,
// contention, outstanding limit and mid-transaction reset.
module tb_mem_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       pf_valid;
  logic [3:0] pf_cmd;
  logic [1:0] pf_data;
  logic       pf_started;
  logic       pf_data_next;
  logic       dp_valid;
  logic       dp_write;
  logic [3:0] dp_cmd;
  logic [1:0] dp_data;
  logic       dp_started;
  logic       dp_data_next;
  logic       rx_reply_done;
  logic [1:0] tx_pins;
  logic       tx_active;
  logic [3:0] tx_counter;
  logic       tx_done;
  logic [1:0] outstanding;

  int total = 0;
  int bad   = 0;
  bit exp_first_dp;

  always #5 clk = ~clk;

  mem_tx_scheduler dut (
    .clk(clk), .reset(reset),
    .pf_valid(pf_valid), .pf_cmd(pf_cmd), .pf_data(pf_data),
    .pf_started(pf_started), .pf_data_next(pf_data_next),
    .dp_valid(dp_valid), .dp_write(dp_write), .dp_cmd(dp_cmd), .dp_data(dp_data),
    .dp_started(dp_started), .dp_data_next(dp_data_next),
    .rx_reply_done(rx_reply_done),
    .tx_pins(tx_pins), .tx_active(tx_active), .tx_counter(tx_counter),
    .tx_done(tx_done), .outstanding(outstanding)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    pf_valid = 0; pf_cmd = 0; pf_data = 0;
    dp_valid = 0; dp_write = 0; dp_cmd = 0; dp_data = 0;
    rx_reply_done = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pf_valid = 1'b1; pf_cmd = 4'h9;
    tick();
    tick();
    #2;
    total++;
    if ({pf_started, dp_started, pf_data_next, dp_data_next, tx_pins, tx_active,
         tx_counter, tx_done, outstanding} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got started=%0b/%0b pins=%0d active=%0b cnt=%0d done=%0b out=%0d want all 0",
               pf_started, dp_started, tx_pins, tx_active, tx_counter, tx_done, outstanding);
    end
    reset = 1'b0; pf_valid = 1'b0;
    tick();
    rx_reply_done = 1'b1;
    tick();
    rx_reply_done = 1'b0;
    #2;
    total++;
    if (outstanding !== 2'd0) begin
      bad++; $display("FAIL reply_at_zero: outstanding=%0d want 0", outstanding);
    end
  endtask

  task automatic test_pf_read();
    tick();
    pf_valid = 1'b1; pf_cmd = 4'b1001; pf_data = 2'd0;
    #2;
    total++;
    if ({pf_started, dp_started, tx_active} !== 3'b100) begin
      bad++; $display("FAIL pf_grant: pf_started=%0b dp_started=%0b active=%0b want 1 0 0", pf_started, dp_started, tx_active);
    end
    tick();
    pf_valid = 1'b0;
    #2;
    total++;
    if ({tx_pins, tx_active, pf_data_next, outstanding} !== {2'b01, 1'b1, 1'b0, 2'd1}) begin
      bad++; $display("FAIL pf_hdr0: pins=%0d active=%0b next=%0b out=%0d want 1 1 0 1", tx_pins, tx_active, pf_data_next, outstanding);
    end
    tick();
    #2;
    total++;
    if (tx_pins !== 2'b10) begin
      bad++; $display("FAIL pf_hdr1: pins=%0d want 2", tx_pins);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      pf_data = 2'(i % 4);
      #2;
      total++;
      if ({tx_pins, tx_counter, pf_data_next, dp_data_next, tx_done} !==
          {2'(i % 4), 4'(i), 1'b1, 1'b0, (i == 7)}) begin
        bad++;
        $display("FAIL pf_addr[%0d]: pins=%0d cnt=%0d pnext=%0b dnext=%0b done=%0b want %0d %0d 1 0 %0b",
                 i, tx_pins, tx_counter, pf_data_next, dp_data_next, tx_done, i % 4, i, i == 7);
      end
    end
    tick();
    #2;
    total++;
    if ({tx_active, tx_done, tx_counter, tx_pins, outstanding} !== {1'b0, 1'b0, 4'd0, 2'd0, 2'd1}) begin
      bad++; $display("FAIL pf_after: active=%0b done=%0b cnt=%0d pins=%0d out=%0d want 0 0 0 0 1",
                      tx_active, tx_done, tx_counter, tx_pins, outstanding);
    end
  endtask

  task automatic test_dp_write();
    int next_cnt = 0;
    tick();
    dp_valid = 1'b1; dp_write = 1'b1; dp_cmd = 4'b0110;
    #2;
    total++;
    if ({dp_started, pf_started} !== 2'b10) begin
      bad++; $display("FAIL dp_grant: dp_started=%0b pf_started=%0b want 1 0", dp_started, pf_started);
    end
    tick();
    dp_valid = 1'b0;
    #2;
    total++;
    if (tx_pins !== 2'b10) begin
      bad++; $display("FAIL dp_hdr0: pins=%0d want 2", tx_pins);
    end
    tick();
    #2;
    total++;
    if (tx_pins !== 2'b01) begin
      bad++; $display("FAIL dp_hdr1: pins=%0d want 1", tx_pins);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      dp_data = 2'(3 - (i % 4));
      #2;
      total++;
      if ({tx_pins, tx_counter, dp_data_next, pf_data_next, tx_done} !==
          {2'(3 - (i % 4)), 4'(i), 1'b1, 1'b0, (i == 15)}) begin
        bad++;
        $display("FAIL dp_payload[%0d]: pins=%0d cnt=%0d dnext=%0b pnext=%0b done=%0b want %0d %0d 1 0 %0b",
                 i, tx_pins, tx_counter, dp_data_next, pf_data_next, tx_done, 3 - (i % 4), i, i == 15);
      end
      if (dp_data_next) next_cnt++;
    end
    total++;
    if (next_cnt != 16) begin
      bad++; $display("FAIL dp_next_count: got %0d want 16", next_cnt);
    end
    tick();
    dp_write = 1'b0;
    #2;
    total++;
    if ({tx_active, outstanding} !== {1'b0, 2'd1}) begin
      bad++; $display("FAIL dp_after: active=%0b out=%0d want 0 1", tx_active, outstanding);
    end
  endtask

  task automatic test_contention();
    int grant_cyc = -1;
    int done_cyc  = -1;
    int exp_cyc;
    bit done_seen = 1'b0;
    apply_reset();
    exp_cyc = exp_first_dp ? 19 : 11;
    tick();
    pf_valid = 1'b1; pf_cmd = 4'h3;
    dp_valid = 1'b1; dp_write = 1'b1; dp_cmd = 4'hC;
    #2;
    total++;
    if ({dp_started, pf_started} !== {exp_first_dp, !exp_first_dp}) begin
      bad++; $display("FAIL tie1: dp_started=%0b pf_started=%0b want %0b %0b", dp_started, pf_started, exp_first_dp, !exp_first_dp);
    end
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        if (exp_first_dp) dp_valid = 1'b0;
        else pf_valid = 1'b0;
      end
      #2;
      if (tx_done) done_cyc = c;
      if (exp_first_dp ? pf_started : dp_started) begin
        grant_cyc = c;
        break;
      end
    end
    total++;
    if (grant_cyc != exp_cyc) begin
      bad++; $display("FAIL loser_grant_cycle: got %0d want %0d", grant_cyc, exp_cyc);
    end
    total++;
    if (grant_cyc != done_cyc + 1) begin
      bad++; $display("FAIL idle_gap: grant=%0d done=%0d want grant=done+1", grant_cyc, done_cyc);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      pf_valid = 1'b0; dp_valid = 1'b0;
      #2;
      if (tx_done) begin
        done_seen = 1'b1;
        break;
      end
    end
    total++;
    if (!done_seen) begin
      bad++; $display("FAIL loser_done_timeout: tx_done=0 want 1 within 30 cycles");
    end
    tick();
    pf_valid = 1'b1; dp_valid = 1'b1;
    #2;
    total++;
    if ({dp_started, pf_started} !== {exp_first_dp, !exp_first_dp}) begin
      bad++; $display("FAIL tie2: dp_started=%0b pf_started=%0b want %0b %0b", dp_started, pf_started, exp_first_dp, !exp_first_dp);
    end
    tick();
    pf_valid = 1'b0; dp_valid = 1'b0; dp_write = 1'b0;
  endtask

  task automatic test_outstanding();
    apply_reset();
    for (int n = 0; n < 2; n++) begin
      tick();
      pf_valid = 1'b1; pf_cmd = 4'h1;
      #2;
      total++;
      if (pf_started !== 1'b1) begin
        bad++; $display("FAIL lim_read%0d_grant: pf_started=%0b want 1", n, pf_started);
      end
      tick();
      pf_valid = 1'b0;
      repeat (9) tick();
    end
    tick();
    pf_valid = 1'b1;
    #2;
    total++;
    if ({pf_started, outstanding} !== {1'b0, 2'd2}) begin
      bad++; $display("FAIL lim_block: pf_started=%0b out=%0d want 0 2", pf_started, outstanding);
    end
    tick();
    dp_valid = 1'b1; dp_write = 1'b1;
    #2;
    total++;
    if ({dp_started, pf_started} !== 2'b10) begin
      bad++; $display("FAIL lim_write_grant: dp_started=%0b pf_started=%0b want 1 0", dp_started, pf_started);
    end
    tick();
    dp_valid = 1'b0;
    repeat (17) tick();
    tick();
    dp_write = 1'b0;
    rx_reply_done = 1'b1;
    #2;
    total++;
    if ({pf_started, outstanding, tx_active} !== {1'b0, 2'd2, 1'b0}) begin
      bad++; $display("FAIL lim_still_blocked: pf_started=%0b out=%0d active=%0b want 0 2 0", pf_started, outstanding, tx_active);
    end
    tick();
    rx_reply_done = 1'b0;
    #2;
    total++;
    if ({pf_started, outstanding} !== {1'b1, 2'd1}) begin
      bad++; $display("FAIL lim_release: pf_started=%0b out=%0d want 1 1", pf_started, outstanding);
    end
    tick();
    pf_valid = 1'b0;
    #2;
    total++;
    if (outstanding !== 2'd2) begin
      bad++; $display("FAIL lim_regrant_count: out=%0d want 2", outstanding);
    end
    repeat (9) tick();
    tick();
    rx_reply_done = 1'b1;
    tick();
    pf_valid = 1'b1;
    #2;
    total++;
    if ({pf_started, outstanding} !== {1'b1, 2'd1}) begin
      bad++; $display("FAIL coincide_grant: pf_started=%0b out=%0d want 1 1", pf_started, outstanding);
    end
    tick();
    pf_valid = 1'b0; rx_reply_done = 1'b0;
    #2;
    total++;
    if (outstanding !== 2'd1) begin
      bad++; $display("FAIL coincide_count: out=%0d want 1", outstanding);
    end
  endtask

  task automatic test_reset_mid();
    bit done_seen = 1'b0;
    apply_reset();
    tick();
    dp_valid = 1'b1; dp_write = 1'b0; dp_cmd = 4'h5;
    #2;
    total++;
    if (dp_started !== 1'b1) begin
      bad++; $display("FAIL mid_grant: dp_started=%0b want 1", dp_started);
    end
    tick();
    dp_valid = 1'b0;
    repeat (5) tick();
    #2;
    total++;
    if ({tx_counter, outstanding, tx_active} !== {4'd3, 2'd1, 1'b1}) begin
      bad++; $display("FAIL mid_position: cnt=%0d out=%0d active=%0b want 3 1 1", tx_counter, outstanding, tx_active);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    total++;
    if ({tx_active, tx_pins, outstanding, tx_counter, tx_done} !== 10'd0) begin
      bad++; $display("FAIL mid_reset: active=%0b pins=%0d out=%0d cnt=%0d done=%0b want all 0",
                      tx_active, tx_pins, outstanding, tx_counter, tx_done);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      #2;
      if (tx_done) done_seen = 1'b1;
    end
    total++;
    if (done_seen) begin
      bad++; $display("FAIL mid_no_done: tx_done seen=1 want 0");
    end
    tick();
    pf_valid = 1'b1; pf_cmd = 4'b1110;
    #2;
    total++;
    if (pf_started !== 1'b1) begin
      bad++; $display("FAIL mid_regrant: pf_started=%0b want 1", pf_started);
    end
    tick();
    pf_valid = 1'b0;
    #2;
    total++;
    if ({tx_pins, outstanding} !== {2'b10, 2'd1}) begin
      bad++; $display("FAIL mid_regrant_hdr: pins=%0d out=%0d want 2 1", tx_pins, outstanding);
    end
  endtask

  initial begin
`ifdef MEM_TX_ROUND_ROBIN_EN
    exp_first_dp = 1'b0;
`else
    exp_first_dp = 1'b1;
`endif
    reset = 1'b1;
    pf_valid = 0; pf_cmd = 0; pf_data = 0;
    dp_valid = 0; dp_write = 0; dp_cmd = 0; dp_data = 0;
    rx_reply_done = 0;
    test_reset();
    test_pf_read();
    test_dp_write();
    test_contention();
    test_outstanding();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
